// File: rtl/instruction_loader_pkg.sv
// Shared types and constants for the instruction loader: state encoding,
// byte-lane geometry and the default HALT word.
package instruction_loader_pkg;

   localparam int unsigned BYTE_LANES = 4;
   localparam int unsigned BYTE_W     = 8;
   localparam int unsigned INST_W     = BYTE_LANES * BYTE_W;
   localparam int unsigned BYTE_CNT_W = $clog2(BYTE_LANES);

   localparam logic [INST_W-1:0] HALT_INSTRUCTION_DEFAULT = 32'hFFFF_FFFF;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RECV  = 3'd1,
      ST_DONE  = 3'd2,
      ST_ERROR = 3'd3,
      ST_CHECK = 3'd4
   } state_e;

endpackage

// File: rtl/loader_word_assembler.sv
// Packs accepted bytes little-endian into a 32-bit word; flags the cycle in
// which the fourth byte arrives and presents the completed word combinationally.
module loader_word_assembler
   import instruction_loader_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_clear,
   input  logic              i_accept,
   input  logic [BYTE_W-1:0] i_byte,
   output logic              o_word_ready_c,
   output logic [INST_W-1:0] o_word_c
);

   logic [BYTE_CNT_W-1:0] byte_cnt_q, byte_cnt_d;
   logic [INST_W-1:0]     lanes_q, lanes_d;

   // Merge the incoming byte into its lane so the full word is usable this cycle.
   always_comb begin
      lanes_d        = lanes_q;
      byte_cnt_d     = byte_cnt_q;
      o_word_c       = lanes_q;
      o_word_c[32'(byte_cnt_q) * BYTE_W +: BYTE_W] = i_byte;
      o_word_ready_c = i_accept && (byte_cnt_q == BYTE_CNT_W'(BYTE_LANES - 1));
      if (i_clear) begin
         lanes_d    = '0;
         byte_cnt_d = '0;
      end else if (i_accept) begin
         lanes_d    = o_word_c;
         byte_cnt_d = byte_cnt_q + BYTE_CNT_W'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         lanes_q    <= '0;
         byte_cnt_q <= '0;
      end else begin
         lanes_q    <= lanes_d;
         byte_cnt_q <= byte_cnt_d;
      end
   end

endmodule

// File: rtl/instruction_loader.sv
// Instruction-memory writer: assembles UART bytes into words and writes them
// at incrementing byte addresses until HALT. Optional LOADER_CHECKSUM_EN adds
// a trailing XOR checksum byte verified after the HALT write.
module instruction_loader
   import instruction_loader_pkg::*;
#(
   parameter int unsigned       INST_MEM_ADDR_WIDTH = 9,
   parameter logic [INST_W-1:0] HALT_INSTRUCTION    = HALT_INSTRUCTION_DEFAULT
) (
   input  logic                           i_clk,
   input  logic                           i_reset,
   input  logic                           i_start,
   input  logic [BYTE_W-1:0]              i_rx_data,
   input  logic                           i_rx_valid,
   output logic                           o_write_instruction_flag,
   output logic [INST_W-1:0]              o_instruction_to_write,
   output logic [INST_MEM_ADDR_WIDTH-1:0] o_address_to_write_inst,
   output logic                           o_loading,
   output logic                           o_done,
   output logic                           o_error
);

   localparam logic [INST_MEM_ADDR_WIDTH-1:0] ADDR_STEP = INST_MEM_ADDR_WIDTH'(BYTE_LANES);
   localparam logic [INST_MEM_ADDR_WIDTH-1:0] LAST_ADDR = ~INST_MEM_ADDR_WIDTH'(BYTE_LANES - 1);

   state_e                           state_q;
   logic [INST_MEM_ADDR_WIDTH-1:0]   addr_q;
   logic [INST_MEM_ADDR_WIDTH-1:0]   wr_addr_q;
   logic [INST_W-1:0]                inst_q;
   logic                             wr_flag_q;
   logic                             loading_q;
   logic                             done_q;
   logic                             error_q;
`ifdef LOADER_CHECKSUM_EN
   logic [BYTE_W-1:0]                chk_q;
`endif

   logic              accept_c;
   logic              clear_c;
   logic              word_ready_c;
   logic [INST_W-1:0] word_c;

   assign accept_c = (state_q == ST_RECV) && i_rx_valid;
   assign clear_c  = i_start && ((state_q == ST_IDLE) || (state_q == ST_DONE) ||
                                 (state_q == ST_ERROR));

   loader_word_assembler u_asm (
      .i_clk          (i_clk),
      .i_reset        (i_reset),
      .i_clear        (clear_c),
      .i_accept       (accept_c),
      .i_byte         (i_rx_data),
      .o_word_ready_c (word_ready_c),
      .o_word_c       (word_c)
   );

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q   <= ST_IDLE;
         addr_q    <= '0;
         wr_addr_q <= '0;
         inst_q    <= '0;
         wr_flag_q <= 1'b0;
         loading_q <= 1'b0;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         chk_q     <= '0;
`endif
      end else begin
         wr_flag_q <= 1'b0;
         case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
               if (i_start) begin
                  state_q   <= ST_RECV;
                  addr_q    <= '0;
                  loading_q <= 1'b1;
                  done_q    <= 1'b0;
                  error_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                  chk_q     <= '0;
`endif
               end
            end
            ST_RECV: begin
`ifdef LOADER_CHECKSUM_EN
               if (accept_c) chk_q <= chk_q ^ i_rx_data;
`endif
               if (word_ready_c) begin
                  wr_flag_q <= 1'b1;
                  inst_q    <= word_c;
                  wr_addr_q <= addr_q;
                  addr_q    <= addr_q + ADDR_STEP;
                  // HALT wins over overflow when it lands in the last slot.
                  if (word_c == HALT_INSTRUCTION) begin
`ifdef LOADER_CHECKSUM_EN
                     state_q   <= ST_CHECK;
`else
                     state_q   <= ST_DONE;
                     loading_q <= 1'b0;
                     done_q    <= 1'b1;
`endif
                  end else if (addr_q == LAST_ADDR) begin
                     state_q   <= ST_ERROR;
                     loading_q <= 1'b0;
                     error_q   <= 1'b1;
                  end
               end
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CHECK: begin
               if (i_rx_valid) begin
                  loading_q <= 1'b0;
                  if (i_rx_data == chk_q) begin
                     state_q <= ST_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= ST_ERROR;
                     error_q <= 1'b1;
                  end
               end
            end
`endif
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign o_write_instruction_flag = wr_flag_q;
   assign o_instruction_to_write   = inst_q;
   assign o_address_to_write_inst  = wr_addr_q;
   assign o_loading                = loading_q;
   assign o_done                   = done_q;
   assign o_error                  = error_q;

endmodule

// File: doc/instruction_loader.md
Name: instruction_loader

Overview:
- Writer side of the instruction-memory programming interface of the IF stage.
- Takes a byte stream from the debug/UART receiver, assembles little-endian 32-bit instructions and issues single-cycle word writes with incrementing byte addresses.
- Loading ends when the HALT instruction word is written.
- Owns the IF stage's write flag, write data and write address inputs, and holds the pipeline in reset/stall while loading.

Parameters:
- INST_MEM_ADDR_WIDTH, 9: byte address width of instruction memory (2^9 bytes = 128 words).
- HALT_INSTRUCTION, 32'hFFFF_FFFF: word that terminates a load; it is written, then loading ends.

Ports:
- i_clk  in  1  clock, single domain.
- i_reset  in  1  synchronous, active-high reset.
- i_start  in  1  pulse; begins a load from address 0.
- i_rx_data  in  8  received byte.
- i_rx_valid  in  1  one-cycle strobe; i_rx_data is valid this cycle.
- o_write_instruction_flag  out  1  one-cycle write enable to the IF stage.
- o_instruction_to_write  out  32  assembled instruction.
- o_address_to_write_inst  out  INST_MEM_ADDR_WIDTH  byte address of the word (multiple of 4).
- o_loading  out  1  high in RECV; the system holds the pipeline stalled.
- o_done  out  1  level; high in DONE.
- o_error  out  1  level; high in ERROR.

Behaviour:
- Reset: state IDLE; all outputs 0; byte counter 0; word address 0; shift register 0.
- States: IDLE, RECV, DONE, ERROR. All outputs registered.
- IDLE: i_start -> RECV; clear address and byte counter. i_rx_valid in IDLE is ignored.
- RECV: each i_rx_valid byte goes to lane [byte_cnt*8 +: 8], so the first byte is [7:0] (little-endian); byte_cnt then increments mod 4.
- Fourth byte accepted at cycle N: at N+1, o_write_instruction_flag=1 for exactly one cycle, o_instruction_to_write holds the word and o_address_to_write_inst holds the current word address.
  - Word address then advances by 4.
  - Data and address stay stable until the next write.
- Back-to-back bytes (i_rx_valid every cycle) are accepted with no gaps. A byte arriving in the same cycle as the write pulse becomes byte 0 of the next word.
- If the completed word equals HALT_INSTRUCTION, the write still occurs. Next state is DONE (without CHECKSUM_EN), o_loading drops the same cycle the write pulse is asserted.
- Overflow: a non-HALT word completing at address 2^W-4 is written, then state -> ERROR (the next address would wrap). The address never wraps silently.
- DONE/ERROR: outputs hold; bytes are ignored; i_start re-enters RECV, clears o_done/o_error and restarts at address 0.
- i_start while in RECV: ignored.
- i_reset mid-load: immediate return to IDLE; a partial word is discarded and no write is issued that cycle.
- Exactly one write per 4 accepted bytes; never two write pulses in consecutive cycles.

Optional Feature:
- Macro LOADER_CHECKSUM_EN.
- Defined:
  - A running 8-bit XOR of all accepted bytes is kept, including the HALT bytes.
  - After the HALT write, state CHECK waits for one more byte.
  - Byte equals the XOR -> DONE; otherwise -> ERROR.
  - o_loading stays high in CHECK.
- Undefined: no CHECK state; HALT -> DONE directly.

Decomposition:
- Shared package/header holds:
  - state encodings (IDLE=0, RECV=1, DONE=2, ERROR=3, CHECK=4);
  - the HALT_INSTRUCTION default;
  - the byte-lane constant 4.
- One natural sub-module: loader_word_assembler (byte counter + shift lanes + word_ready pulse). The FSM, address counter and checksum stay in the top.

Test Plan:
- Reset, i_start, bytes 13 00 00 20 (valid every cycle) -> one pulse, data 32'h20000013, addr 0; then bytes FF FF FF FF -> pulse, data 32'hFFFFFFFF, addr 4; o_done=1 the next cycle.
- Bytes spaced 3 idle cycles apart, 3 words then HALT -> writes at addrs 0, 4, 8, 12; exactly 4 pulses; data stable between pulses.
- 128 non-HALT words -> last write at addr 508, then o_error=1; no write with addr 0 after the start.
- i_reset asserted after 2 bytes of word 1 -> no pulse; IDLE; a new i_start plus 4 bytes writes addr 0 with the new bytes only.
- Bytes while in IDLE and DONE -> no writes; i_start in DONE -> o_done=0, next word written at addr 0.
- LOADER_CHECKSUM_EN: word 01 02 03 04 + HALT, then byte 04 -> DONE; then repeat with byte 05 -> ERROR.
